pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Front-end PC sequencer signal bundle: control/target inputs driven by the
// pipeline, PC and return-address-stack status returned by the sequencer.
// pc_en is a plain qualifier with no backpressure: when it is high at a rising
// clock edge the PC advances or redirects, and it is never stalled by the sequencer.
interface pc_sequencer_if;
  logic        pc_en;
  logic [2:0]  PCSrc;
  logic [31:0] rdat1;
  logic [25:0] immediate26;
  logic [31:0] branch_addr;
  logic        flush;
  logic [31:0] flush_addr;
  logic        exc;
  logic        ras_clr;
  logic [31:0] imemaddr;
  logic [31:0] pc_plus_4;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;
  logic [4:0]  ras_count;

  modport master (
    output pc_en, PCSrc, rdat1, immediate26, branch_addr, flush, flush_addr, exc, ras_clr,
    input  imemaddr, pc_plus_4, ras_empty, ras_full, ras_ovf, ras_unf, ras_count
  );

  modport slave (
    input  pc_en, PCSrc, rdat1, immediate26, branch_addr, flush, flush_addr, exc, ras_clr,
    output imemaddr, pc_plus_4, ras_empty, ras_full, ras_ovf, ras_unf, ras_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with prioritised redirects (exception, flush,
// jump/branch) and a circular return-address stack for JAL/RET prediction.
module pc_sequencer #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0080,
  parameter int          RAS_DEPTH = 4
) (
  input logic           CLK,
  input logic           RST,
  pc_sequencer_if.slave bus
);
  localparam int         PW      = $clog2(RAS_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(RAS_DEPTH);

  localparam logic [2:0] SRC_JR     = 3'd0;
  localparam logic [2:0] SRC_JUMP   = 3'd1;
  localparam logic [2:0] SRC_BRANCH = 3'd2;
  localparam logic [2:0] SRC_JAL    = 3'd4;
  localparam logic [2:0] SRC_RET    = 3'd5;

  logic [31:0]   pc, pc_next, pc_plus_4, jump_tgt;
  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] top, top_next;
  logic [4:0]    count, count_next, eff_count;
  logic          ovf, ovf_next, unf, unf_next, push;

  assign pc_plus_4 = pc + 32'd4;
  assign jump_tgt  = {pc_plus_4[31:28], bus.immediate26, 2'b00};
  // A same-cycle clear wins over any push/pop, even during exc/flush.
  assign eff_count = bus.ras_clr ? 5'd0 : count;

  always_comb begin
    pc_next    = pc;
    top_next   = top;
    count_next = eff_count;
    ovf_next   = ovf;
    unf_next   = unf;
    push       = 1'b0;
    if (bus.exc) begin
      pc_next = EXC_VEC;
    end else if (bus.flush) begin
      pc_next = bus.flush_addr;
    end else if (bus.pc_en) begin
      case (bus.PCSrc)
        SRC_JR:     pc_next = bus.rdat1;
        SRC_JUMP:   pc_next = jump_tgt;
        SRC_BRANCH: pc_next = bus.branch_addr;
        SRC_JAL: begin
          pc_next  = jump_tgt;
          push     = 1'b1;
          top_next = top + PW'(1);
          // A full stack drops its oldest entry; the new one lands on top of it.
          if (eff_count == DEPTH_C) ovf_next = 1'b1;
          else                      count_next = eff_count + 5'd1;
        end
        SRC_RET: begin
          if (eff_count != 5'd0) begin
            pc_next    = ras_mem[top];
            top_next   = top - PW'(1);
            count_next = eff_count - 5'd1;
          end else begin
            pc_next  = bus.rdat1;
            unf_next = 1'b1;
          end
        end
        default:    pc_next = pc_plus_4;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc    <= PC_INIT;
      top   <= '0;
      count <= 5'd0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      pc    <= pc_next;
      top   <= top_next;
      count <= count_next;
      ovf   <= ovf_next;
      unf   <= unf_next;
    end
  end

  // Entry contents need no reset; count gates whether any entry is visible.
  always_ff @(posedge CLK) begin
    if (push && !RST) ras_mem[top + PW'(1)] <= pc_plus_4;
  end

  assign bus.imemaddr  = pc;
  assign bus.pc_plus_4 = pc_plus_4;
  assign bus.ras_empty = (count == 5'd0);
  assign bus.ras_full  = (count == DEPTH_C);
  assign bus.ras_ovf   = ovf;
  assign bus.ras_unf   = unf;
  assign bus.ras_count = count;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, all checked
// against a queue-based model of the PC and return-address stack.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0080;
  localparam int          RAS_D   = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_sequencer_if bus();

  pc_sequencer #(.PC_INIT(PC_INIT), .EXC_VEC(EXC_VEC), .RAS_DEPTH(RAS_D)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic        m_ovf, m_unf;
  logic [31:0] exp_q[$];   // RAS contents, oldest at front

  task automatic model_reset();
    m_pc  = PC_INIT;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (bus.ras_clr) exp_q.delete();
    if (bus.exc) m_pc = EXC_VEC;
    else if (bus.flush) m_pc = bus.flush_addr;
    else if (bus.pc_en) begin
      case (bus.PCSrc)
        3'd0: m_pc = bus.rdat1;
        3'd1: m_pc = {seq[31:28], bus.immediate26, 2'b00};
        3'd2: m_pc = bus.branch_addr;
        3'd4: begin
          if (exp_q.size() == RAS_D) begin
            void'(exp_q.pop_front());
            m_ovf = 1'b1;
          end
          exp_q.push_back(seq);
          m_pc = {seq[31:28], bus.immediate26, 2'b00};
        end
        3'd5: begin
          if (exp_q.size() > 0) m_pc = exp_q.pop_back();
          else begin
            m_pc  = bus.rdat1;
            m_unf = 1'b1;
          end
        end
        default: m_pc = seq;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    bus.imemaddr, m_pc);
    check({tag, ".pc4"},   bus.pc_plus_4, m_pc + 32'd4);
    check({tag, ".cnt"},   32'(bus.ras_count), 32'(exp_q.size()));
    check({tag, ".empty"}, 32'(bus.ras_empty), 32'(exp_q.size() == 0));
    check({tag, ".full"},  32'(bus.ras_full), 32'(exp_q.size() == RAS_D));
    check({tag, ".ovf"},   32'(bus.ras_ovf), 32'(m_ovf));
    check({tag, ".unf"},   32'(bus.ras_unf), 32'(m_unf));
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input string tag, input logic en, input logic [2:0] src,
                       input logic [31:0] r1, input logic [25:0] imm, input logic [31:0] br,
                       input logic fl, input logic [31:0] fa, input logic ex, input logic clr);
    bus.pc_en       = en;
    bus.PCSrc       = src;
    bus.rdat1       = r1;
    bus.immediate26 = imm;
    bus.branch_addr = br;
    bus.flush       = fl;
    bus.flush_addr  = fa;
    bus.exc         = ex;
    bus.ras_clr     = clr;
    model_step();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic op(input string tag, input logic [2:0] src, input logic [31:0] r1, input logic [25:0] imm);
    drive(tag, 1'b1, src, r1, imm, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic go_to(input logic [31:0] addr);
    drive("flush", 1'b0, 3'd3, 32'h0, 26'h0, 32'h0, 1'b1, addr, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive_idle();
    RST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic drive_idle();
    bus.pc_en = 1'b0; bus.PCSrc = 3'd3; bus.rdat1 = 32'h0; bus.immediate26 = 26'h0;
    bus.branch_addr = 32'h0; bus.flush = 1'b0; bus.flush_addr = 32'h0;
    bus.exc = 1'b0; bus.ras_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] pcs [5];
  logic [4:0]  cnt_before;

  initial begin
    model_reset();
    do_reset();

    // Sequential fetch from reset.
    op("seq1", 3'd3, 32'h0, 26'h0);
    op("seq2", 3'd3, 32'h0, 26'h0);
    op("seq3", 3'd3, 32'h0, 26'h0);
    check("seq_end_pc", bus.imemaddr, 32'h0000_000C);

    // JAL then RET round trip.
    go_to(32'h0040_0010);
    op("jal", 3'd4, 32'h0, 26'h0000100);
    check("jal_pc", bus.imemaddr, 32'h0000_0400);
    op("ret", 3'd5, 32'h0, 26'h0);
    check("ret_pc", bus.imemaddr, 32'h0040_0014);
    check("ret_empty", 32'(bus.ras_empty), 32'd1);

    // Overflow then drain past empty.
    for (int i = 0; i < 5; i++) begin
      pcs[i] = 32'h0001_0000 * (i + 1) + 32'h100;
      go_to(pcs[i]);
      op("ovf_jal", 3'd4, 32'h0, 26'($urandom));
    end
    check("ovf_full", 32'(bus.ras_full), 32'd1);
    check("ovf_flag", 32'(bus.ras_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      op("drain_ret", 3'd5, 32'h0, 26'h0);
      check("drain_pc", bus.imemaddr, pcs[4-i] + 32'd4);
    end
    op("unf_ret", 3'd5, 32'hDEAD_0000, 26'h0);
    check("unf_pc", bus.imemaddr, 32'hDEAD_0000);
    check("unf_flag", 32'(bus.ras_unf), 32'd1);

    // Exception beats flush and a JAL; RAS untouched.
    op("pre_jal", 3'd4, 32'h0, 26'h12345);
    cnt_before = bus.ras_count;
    drive("exc_all", 1'b1, 3'd4, 32'h0, 26'h3, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    check("exc_pc", bus.imemaddr, EXC_VEC);
    check("exc_cnt", 32'(bus.ras_count), 32'(cnt_before));

    // RET together with clear on a non-empty stack, from fresh flags.
    do_reset();
    op("clr_jal", 3'd4, 32'h0, 26'h40);
    drive("ret_clr", 1'b1, 3'd5, 32'hCAFE_0004, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("retclr_pc", bus.imemaddr, 32'hCAFE_0004);
    check("retclr_unf", 32'(bus.ras_unf), 32'd1);
    check("retclr_empty", 32'(bus.ras_empty), 32'd1);

    // Asynchronous reset between edges, then PC wrap.
    for (int i = 0; i < 5; i++) op("fill_jal", 3'd4, 32'h0, 26'($urandom));
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_pc", bus.imemaddr, PC_INIT);
    #1;
    RST = 1'b0;
    go_to(32'hFFFF_FFFC);
    check("wrap_pc4", bus.pc_plus_4, 32'h0000_0000);
    op("wrap_seq", 3'd3, 32'h0, 26'h0);
    check("wrap_pc", bus.imemaddr, 32'h0000_0000);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive("rand",
            1'($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)),
            $urandom & 32'hFFFF_FFFC,
            26'($urandom),
            $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 15) == 0),
            $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 11) == 0));
      if (i == 200) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
